btb_update_scheduler: RTL
=========================

# btb_update_scheduler

Write-port controller for the branch target buffer. It collects IF-stage allocation requests (BTB miss on a branch) and ID-stage resolution updates, and queues them in a small FIFO. It issues them one per cycle over a single BTB write port and owns victim-line selection for allocations. It sits between the IF/ID pipeline stages and the BTB, and replaces direct, unarbitrated writes with an ordered, back-pressured update stream.

## Interface
Parameters:
- DATA_WIDTH, 32, pc/target width
- QUEUE_DEPTH, 4, pending-update FIFO entries (power of two, ≥2)
- LINE_NUM / LINE_BITS, `BTB_LINE_NUM` (8) / `BTB_LINE_SIZE` (3), from defines.vh

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  global enable; low: no enqueue, no issue, replacement state frozen
- IF_alloc_req  in  1  IF branch missed in BTB
- IF_alloc_pc, IF_alloc_target  in  DATA_WIDTH  tag / predicted target
- ID_upd_req  in  1  ID-stage branch resolved
- ID_upd_pc, ID_upd_target  in  DATA_WIDTH  tag / resolved target
- ID_upd_hit  in  1  ID pc hit in BTB
- ID_upd_line  in  LINE_BITS  hit line (valid when ID_upd_hit)
- ID_misprediction  in  1  prediction was wrong
- IF_touch, IF_touch_line  in  1 / LINE_BITS  BTB hit in IF, for replacement
- wr_ready  in  1  BTB accepts a write this cycle
- wr_valid  out  1  write pending at FIFO head
- wr_alloc  out  1  1: full-entry rewrite (valid=1, WEAKLY_TAKEN); 0: target + 2-bit counter update
- wr_line  out  LINE_BITS  target line
- wr_tag, wr_target  out  DATA_WIDTH
- wr_misprediction  out  1  counter-update direction
- victim_line  out  LINE_BITS  current replacement choice
- full  out  1  fewer than 2 free slots; pipeline must stall
- ovf_cnt  out  8  saturating count of dropped requests

## Operation
- Each FIFO entry holds {alloc, hit_line, tag, target, mispred}.
- ID_upd_req pushes alloc = ~ID_upd_hit. IF_alloc_req pushes alloc = 1, mispred = 0.
- Same-cycle push order is ID first, then IF, because ID holds the older instruction. With one free slot, ID is enqueued and IF is dropped (ovf_cnt+1).
- Coalescing: an IF alloc whose pc equals the tag of any queued alloc entry, or of the same-cycle ID push, is discarded silently (no ovf).
- Issue: wr_valid = ~empty & en. The head pops on wr_valid & wr_ready.
  - For an alloc entry, wr_line = victim_line sampled in the issue cycle.
  - For a hit entry, wr_line = stored hit_line.
- Push and pop in the same cycle are legal at any occupancy, including full; count is unchanged.
- Replacement touch happens on IF_touch (IF_touch_line) and on every issued write (wr_line).
  - If both occur in one cycle, the issued write is applied last and becomes MRU.
- ovf_cnt saturates at 255 and clears only on reset.

## Timing
- Registered FIFO: a request sampled at edge t is visible as wr_valid after edge t (1-cycle latency). There is no combinational path from the request inputs to the wr_* outputs.
- full and wr_* are functions of registered state only.
- Reset (rst low, any time, asynchronous) empties the FIFO and clears replacement state and ovf_cnt.
  - Reset values: wr_valid=0, wr_alloc=0, wr_line=0, wr_tag=0, wr_target=0, wr_misprediction=0, victim_line=0, full=0, ovf_cnt=0.
  - In-flight entries are lost.
- en low holds all state. wr_valid reads 0 while en is low, and pushes are ignored (not counted).

## Configuration
- BTB_PLRU_EN defined: 7-bit tree pseudo-LRU.
  - Node 0 is the root and the children of node n are 2n+1 and 2n+2. A bit value of 0 points left.
  - victim_line follows the bits from the root. A touch sets every bit on the path to point away from the touched line.
  - Requires LINE_NUM = 8.
- BTB_PLRU_EN undefined: round-robin. victim_line is a LINE_BITS counter that increments on each issued alloc write; touches are ignored.

## Structure
- Shared package / defines.vh: BTB_LINE_NUM, BTB_LINE_SIZE, and the predictor encodings (STRONGLY/WEAKLY_[NOT_]TAKEN) used by the BTB counter update. Add BTB_UPD_QUEUE_DEPTH there.
- One sub-module, btb_replacement: owns the PLRU / round-robin state.
  - Inputs: touch ports, alloc-issue strobe.
  - Output: victim_line.
- The FIFO is inline.

## Test plan
- Reset, then ID_upd_req (hit=1, line=5, pc=0x40, target=0x80, mispred=1) with wr_ready=1 → next cycle wr_valid=1, wr_alloc=0, wr_line=5, wr_target=0x80, wr_misprediction=1; FIFO empty after.
- PLRU build: reset, IF_alloc_req pc=0x10 → wr_line=0, wr_alloc=1; after the issue, victim_line=4. Touch line 4 → victim_line=2.
- Back-pressure: wr_ready=0, push 3 IDs → full=1 after the 3rd. The 4th cycle pushes both ID and IF → ID accepted, IF dropped, ovf_cnt=1. Release wr_ready → 4 writes issue in push order.
- Coalescing: IF_alloc pc=0x20 on two consecutive cycles with wr_ready=0 → one queued entry, ovf_cnt=0.
- Async reset: assert rst low mid-cycle with 3 entries queued → wr_valid=0 and full=0 immediately; no write issues after release.
- Round-robin build: 9 consecutive alloc issues → wr_line sequence 0..7, 0.

Source files
------------

// File: rtl/btb_update_scheduler_pkg.sv
// Shared BTB constants, predictor encodings and pseudo-LRU tree helpers.
package btb_update_scheduler_pkg;

    localparam int unsigned BTB_LINE_NUM        = 8;
    localparam int unsigned BTB_LINE_SIZE       = 3;
    localparam int unsigned BTB_UPD_QUEUE_DEPTH = 4;

    // 2-bit branch predictor states; an allocation writes WeaklyTaken
    typedef enum logic [1:0] {
        StronglyNotTaken = 2'b00,
        WeaklyNotTaken   = 2'b01,
        WeaklyTaken      = 2'b10,
        StronglyTaken    = 2'b11
    } btb_pred_e;

    // Walk the 7-bit tree from the root; node n has children 2n+1 / 2n+2, 0 = left.
    function automatic logic [2:0] plru_victim(input logic [6:0] tree);
        logic n0, n1, n2;
        n0 = tree[0];
        n1 = n0 ? tree[2] : tree[1];
        unique case ({n0, n1})
            2'b00:   n2 = tree[3];
            2'b01:   n2 = tree[4];
            2'b10:   n2 = tree[5];
            default: n2 = tree[6];
        endcase
        return {n0, n1, n2};
    endfunction

    // Point every node on the path to line away from it.
    function automatic logic [6:0] plru_touch(input logic [6:0] tree, input logic [2:0] line);
        logic [6:0] t;
        t    = tree;
        t[0] = ~line[2];
        if (line[2]) t[2] = ~line[1];
        else         t[1] = ~line[1];
        unique case (line[2:1])
            2'b00:   t[3] = ~line[0];
            2'b01:   t[4] = ~line[0];
            2'b10:   t[5] = ~line[0];
            default: t[6] = ~line[0];
        endcase
        return t;
    endfunction

endpackage

// File: rtl/btb_replacement.sv
// BTB victim-line selection. BTB_PLRU_EN selects a 7-bit tree pseudo-LRU (8 lines);
// otherwise a round-robin counter that advances on each issued allocation.
// Callers gate all strobes with the global enable.
module btb_replacement
    import btb_update_scheduler_pkg::*;
#(
    parameter int unsigned LINE_NUM  = BTB_LINE_NUM,
    parameter int unsigned LINE_BITS = BTB_LINE_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 touch_valid,
    input  logic [LINE_BITS-1:0] touch_line,
    input  logic                 issue_valid,
    input  logic                 issue_alloc,
    input  logic [LINE_BITS-1:0] issue_line,
    output logic [LINE_BITS-1:0] victim_line
);

`ifdef BTB_PLRU_EN
    logic [6:0] tree_q, tree_d;
    logic       unused_alloc;

    assign unused_alloc = issue_alloc;

    // IF touch first, issued write last so it ends up MRU
    always_comb begin
        tree_d = tree_q;
        if (touch_valid) tree_d = plru_touch(tree_d, 3'(touch_line));
        if (issue_valid) tree_d = plru_touch(tree_d, 3'(issue_line));
    end

    // Tree state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tree_q <= '0;
        else      tree_q <= tree_d;
    end

    assign victim_line = LINE_BITS'(plru_victim(tree_q));
`else
    logic [LINE_BITS-1:0] rr_q;
    logic                 unused_touch;

    assign unused_touch = ^{touch_valid, touch_line, issue_line};

    // Round-robin pointer advances only when an allocation is written
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q <= '0;
        end else if (issue_valid && issue_alloc) begin
            rr_q <= (rr_q == LINE_BITS'(LINE_NUM - 1)) ? '0 : rr_q + 1'b1;
        end
    end

    assign victim_line = rr_q;
`endif

endmodule

// File: rtl/btb_update_scheduler.sv
// BTB write-port controller: queues ID resolution updates and IF allocations in a
// small FIFO and issues them one per cycle. Replacement policy selected by BTB_PLRU_EN.
module btb_update_scheduler
    import btb_update_scheduler_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned QUEUE_DEPTH = BTB_UPD_QUEUE_DEPTH,
    parameter int unsigned LINE_NUM    = BTB_LINE_NUM,
    parameter int unsigned LINE_BITS   = BTB_LINE_SIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  IF_alloc_req,
    input  logic [DATA_WIDTH-1:0] IF_alloc_pc,
    input  logic [DATA_WIDTH-1:0] IF_alloc_target,
    input  logic                  ID_upd_req,
    input  logic [DATA_WIDTH-1:0] ID_upd_pc,
    input  logic [DATA_WIDTH-1:0] ID_upd_target,
    input  logic                  ID_upd_hit,
    input  logic [LINE_BITS-1:0]  ID_upd_line,
    input  logic                  ID_misprediction,
    input  logic                  IF_touch,
    input  logic [LINE_BITS-1:0]  IF_touch_line,
    input  logic                  wr_ready,
    output logic                  wr_valid,
    output logic                  wr_alloc,
    output logic [LINE_BITS-1:0]  wr_line,
    output logic [DATA_WIDTH-1:0] wr_tag,
    output logic [DATA_WIDTH-1:0] wr_target,
    output logic                  wr_misprediction,
    output logic [LINE_BITS-1:0]  victim_line,
    output logic                  full,
    output logic [7:0]            ovf_cnt
);

    localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef struct packed {
        logic                  alloc;
        logic [LINE_BITS-1:0]  line;
        logic [DATA_WIDTH-1:0] tag;
        logic [DATA_WIDTH-1:0] target;
        logic                  mispred;
    } entry_t;

    entry_t          mem_q [QUEUE_DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [7:0]      ovf_q, ovf_d;

    entry_t          head, id_entry, if_entry;
    logic            pop, id_push, if_push, id_drop, if_drop;
    logic            if_match, if_coal, if_req;
    logic [CntW-1:0] free_slots;
    logic [PtrW-1:0] if_ptr;

    assign head     = mem_q[rd_ptr_q];
    assign wr_valid = (count_q != '0) && en;
    assign pop      = wr_valid && wr_ready;

    assign wr_alloc         = head.alloc;
    assign wr_line          = head.alloc ? victim_line : head.line;
    assign wr_tag           = head.tag;
    assign wr_target        = head.target;
    assign wr_misprediction = head.mispred;
    assign full             = count_q >= CntW'(QUEUE_DEPTH - 1);
    assign ovf_cnt          = ovf_q;

    assign id_entry = '{alloc: ~ID_upd_hit, line: ID_upd_line, tag: ID_upd_pc,
                        target: ID_upd_target, mispred: ID_misprediction};
    assign if_entry = '{alloc: 1'b1, line: '0, tag: IF_alloc_pc,
                        target: IF_alloc_target, mispred: 1'b0};

    // A pop in the same cycle frees its slot for this cycle's pushes
    assign free_slots = CntW'(QUEUE_DEPTH) - count_q + CntW'(pop);

    // IF alloc matching any occupied alloc entry (head included, even if popping)
    always_comb begin
        if_match = 1'b0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (({1'b0, PtrW'(i) - rd_ptr_q} < count_q) && mem_q[i].alloc &&
                (mem_q[i].tag == IF_alloc_pc)) begin
                if_match = 1'b1;
            end
        end
    end

    // ID is older, so it claims a slot before IF
    assign id_push = en && ID_upd_req && (free_slots != '0);
    assign id_drop = en && ID_upd_req && !id_push;
    assign if_coal = if_match || (id_push && (ID_upd_pc == IF_alloc_pc));
    assign if_req  = en && IF_alloc_req && !if_coal;
    assign if_push = if_req && (free_slots > CntW'(id_push));
    assign if_drop = if_req && !if_push;
    assign if_ptr  = wr_ptr_q + PtrW'(id_push);

    // Pointer, occupancy and saturating overflow next-state
    always_comb begin
        logic [8:0] ovf_sum;
        rd_ptr_d = rd_ptr_q + PtrW'(pop);
        wr_ptr_d = wr_ptr_q + PtrW'(id_push) + PtrW'(if_push);
        count_d  = count_q + CntW'(id_push) + CntW'(if_push) - CntW'(pop);
        ovf_sum  = {1'b0, ovf_q} + 9'(id_drop) + 9'(if_drop);
        ovf_d    = ovf_sum[8] ? 8'hff : ovf_sum[7:0];
    end

    // FIFO state and storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            if (id_push) mem_q[wr_ptr_q] <= id_entry;
            if (if_push) mem_q[if_ptr]   <= if_entry;
        end
    end

    btb_replacement #(
        .LINE_NUM  (LINE_NUM),
        .LINE_BITS (LINE_BITS)
    ) u_replacement (
        .clk         (clk),
        .rst         (rst),
        .touch_valid (IF_touch && en),
        .touch_line  (IF_touch_line),
        .issue_valid (pop),
        .issue_alloc (head.alloc),
        .issue_line  (wr_line),
        .victim_line (victim_line)
    );

endmodule
